// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the loader state encoding, error codes, the instruction/address
// widths shared with the datapath memories, and small decode helpers.
package imem_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int INSN_W = 19;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNT_LO = 4'd1,
    CNT_HI = 4'd2,
    B0     = 4'd3,
    B1     = 4'd4,
    B2     = 4'd5,
    WR     = 4'd6,
    CSUM   = 4'd7,
    DONE   = 4'd8,
    ERROR  = 4'd9
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_PAD   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  // Little-endian word assembly: only the low 3 bits of the third byte are payload.
  function automatic logic [INSN_W-1:0] assemble_word(input logic [7:0] b0,
                                                      input logic [7:0] b1,
                                                      input logic [2:0] b2_lo);
    return {b2_lo, b1, b0};
  endfunction

  // The upper 5 bits of the third byte are padding and must be zero.
  function automatic logic pad_bad(input logic [4:0] b2_hi);
    return |b2_hi;
  endfunction

  // States in which a stream byte can be accepted.
  function automatic logic state_ready(input state_t s);
    case (s)
      CNT_LO, CNT_HI, B0, B1, B2, CSUM: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // States that make up an active load (count through checksum).
  function automatic logic state_busy(input state_t s);
    case (s)
      CNT_LO, CNT_HI, B0, B1, B2, WR, CSUM: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // The CPU is released only when idle or after a successful load.
  function automatic logic state_hold(input state_t s);
    case (s)
      IDLE, DONE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave: the loader side; master: the stream source / memory observer side.
interface imem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int INSN_W = 19
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSN_W-1:0] mem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Accepts CNT_LO, CNT_HI, then N
// three-byte words (plus a trailing XOR checksum byte when the macro
// IMEM_LOADER_CSUM_EN is defined), writes each 19-bit word to consecutive
// addresses from BASE_ADDR and holds the CPU while memory is incomplete.
module imem_loader #(
  parameter int                            ADDR_W    = imem_loader_pkg::ADDR_W,
  parameter int                            INSN_W    = imem_loader_pkg::INSN_W,
  parameter logic [imem_loader_pkg::ADDR_W-1:0] BASE_ADDR = 12'h000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);
  import imem_loader_pkg::*;

  localparam int CNT_W = 12;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t AFTER_WORDS = CSUM;
`else
  localparam state_t AFTER_WORDS = DONE;
`endif

  state_t            state_r;
  state_t            next_s;
  logic              xfer_s;
  logic              start_ok_s;
  logic              err_set_s;
  logic [1:0]        err_val_s;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  idx_r;
  logic [7:0]        b0_r;
  logic [7:0]        b1_r;

  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [INSN_W-1:0] mem_wdata_r;
  logic              cpu_hold_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [1:0]        err_code_r;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_r;
`endif

  assign xfer_s     = bus.in_valid & in_ready_r;
  assign start_ok_s = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERROR));

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign err_code      = err_code_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and error detection on the offending transfer.
  always_comb begin
    next_s    = state_r;
    err_set_s = 1'b0;
    err_val_s = ERR_NONE;
    case (state_r)
      IDLE: begin
        if (start) next_s = CNT_LO;
        else       next_s = IDLE;
      end
      CNT_LO: begin
        if (xfer_s) next_s = CNT_HI;
        else        next_s = CNT_LO;
      end
      CNT_HI: begin
        if (xfer_s) begin
          if (bus.in_data[7:4] != 4'h0) begin
            next_s    = ERROR;
            err_set_s = 1'b1;
            err_val_s = ERR_COUNT;
          end else if ({bus.in_data[3:0], cnt_r[7:0]} == 12'h000) begin
            next_s = AFTER_WORDS;
          end else begin
            next_s = B0;
          end
        end else begin
          next_s = CNT_HI;
        end
      end
      B0: begin
        if (xfer_s) next_s = B1;
        else        next_s = B0;
      end
      B1: begin
        if (xfer_s) next_s = B2;
        else        next_s = B1;
      end
      B2: begin
        if (xfer_s) begin
          if (pad_bad(bus.in_data[7:3])) begin
            next_s    = ERROR;
            err_set_s = 1'b1;
            err_val_s = ERR_PAD;
          end else begin
            next_s = WR;
          end
        end else begin
          next_s = B2;
        end
      end
      WR: begin
        if (idx_r + 12'd1 == cnt_r) next_s = AFTER_WORDS;
        else                        next_s = B0;
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (xfer_s) begin
          if (csum_r != bus.in_data) begin
            next_s    = ERROR;
            err_set_s = 1'b1;
            err_val_s = ERR_CSUM;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = CSUM;
        end
      end
`endif
      DONE, ERROR: begin
        if (start) next_s = CNT_LO;
        else       next_s = state_r;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      cpu_hold_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      in_ready_r <= state_ready(next_s);
      mem_we_r   <= (next_s == WR);
      cpu_hold_r <= state_hold(next_s);
      busy_r     <= state_busy(next_s);
      done_r     <= (next_s == DONE);
      error_r    <= (next_s == ERROR);
      if (start_ok_s) begin
        err_code_r <= ERR_NONE;
      end else if (err_set_s) begin
        err_code_r <= err_val_s;
      end else begin
        err_code_r <= err_code_r;
      end
    end
  end

  // Count capture, word index, byte staging and write address/data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r       <= 12'h000;
      idx_r       <= 12'h000;
      b0_r        <= 8'h00;
      b1_r        <= 8'h00;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= '0;
    end else begin
      if (start_ok_s) begin
        idx_r <= 12'h000;
      end else if (state_r == WR) begin
        idx_r <= idx_r + 12'd1;
      end
      if (xfer_s) begin
        case (state_r)
          CNT_LO: cnt_r[7:0]  <= bus.in_data;
          CNT_HI: cnt_r[11:8] <= bus.in_data[3:0];
          B0:     b0_r        <= bus.in_data;
          B1:     b1_r        <= bus.in_data;
          B2: begin
            if (!pad_bad(bus.in_data[7:3])) begin
              mem_wdata_r <= INSN_W'(assemble_word(b0_r, b1_r, bus.in_data[2:0]));
              mem_addr_r  <= BASE_ADDR + ADDR_W'(idx_r);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR over count and word bytes, restarted at each load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_r <= 8'h00;
    end else if (start_ok_s) begin
      csum_r <= 8'h00;
    end else if (xfer_s && (state_r != CSUM)) begin
      csum_r <= csum_r ^ bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed byte streams, expected
// memory writes queued at stimulus time and popped by a write monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

`ifdef IMEM_LOADER_CSUM_EN
  localparam int LAT_WORD = 0;
`else
  localparam int LAT_WORD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       gap = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       start0, start1;
  logic       hold0, busy0, done0, error0;
  logic       hold1, busy1, done1, error1;
  logic [1:0] code0, code1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [30:0] exp0[$];
  logic [30:0] exp1[$];
  logic [7:0]  stream[$];
  logic [7:0]  csum_acc;

  imem_loader_if #(.ADDR_W(12), .INSN_W(19)) if0 ();
  imem_loader_if #(.ADDR_W(12), .INSN_W(19)) if1 ();

  assign if0.in_data  = in_data;
  assign if1.in_data  = in_data;
  assign if0.in_valid = in_valid & ~sel;
  assign if1.in_valid = in_valid & sel;
  assign start0       = start & ~sel;
  assign start1       = start & sel;

  imem_loader #(.BASE_ADDR(12'h000)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(if0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .error(error0), .err_code(code0)
  );

  imem_loader #(.BASE_ADDR(12'hFFF)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(if1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .error(error1), .err_code(code1)
  );

  logic       st_ready, st_hold, st_busy, st_done, st_error;
  logic [1:0] st_code;
  assign st_ready = sel ? if1.in_ready : if0.in_ready;
  assign st_hold  = sel ? hold1  : hold0;
  assign st_busy  = sel ? busy1  : busy0;
  assign st_done  = sel ? done1  : done0;
  assign st_error = sel ? error1 : error0;
  assign st_code  = sel ? code1  : code0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (if0.mem_we) begin
      n_tests++;
      if (exp0.size() == 0) begin
        n_fail++;
        $display("FAIL wr0_unexpected: got %h@%h expected no write", if0.mem_wdata, if0.mem_addr);
      end else if ({if0.mem_addr, if0.mem_wdata} !== exp0[0]) begin
        n_fail++;
        $display("FAIL wr0: got %h@%h expected %h@%h", if0.mem_wdata, if0.mem_addr,
                 exp0[0][18:0], exp0[0][30:19]);
        void'(exp0.pop_front());
      end else begin
        void'(exp0.pop_front());
      end
    end
    if (if1.mem_we) begin
      n_tests++;
      if (exp1.size() == 0) begin
        n_fail++;
        $display("FAIL wr1_unexpected: got %h@%h expected no write", if1.mem_wdata, if1.mem_addr);
      end else if ({if1.mem_addr, if1.mem_wdata} !== exp1[0]) begin
        n_fail++;
        $display("FAIL wr1: got %h@%h expected %h@%h", if1.mem_wdata, if1.mem_addr,
                 exp1[0][18:0], exp1[0][30:19]);
        void'(exp1.pop_front());
      end else begin
        void'(exp1.pop_front());
      end
    end
  end

  task automatic check_status(input string tag, input int d, input int e, input int code,
                              input int hold, input int bsy, input int rdy);
    chk({tag, "_done"},  st_done,  d);
    chk({tag, "_error"}, st_error, e);
    chk({tag, "_code"},  st_code,  code);
    chk({tag, "_hold"},  st_hold,  hold);
    chk({tag, "_busy"},  st_busy,  bsy);
    chk({tag, "_ready"}, st_ready, rdy);
  endtask

  task automatic add_byte(input logic [7:0] b);
    stream.push_back(b);
    csum_acc = csum_acc ^ b;
  endtask

  task automatic begin_load(input logic [11:0] n);
    stream.delete();
    csum_acc = 8'h00;
    add_byte(n[7:0]);
    add_byte({4'h0, n[11:8]});
  endtask

  task automatic add_word(input logic [18:0] w, input logic [11:0] a);
    add_byte(w[7:0]);
    add_byte(w[15:8]);
    add_byte({5'b00000, w[18:16]});
    if (sel) exp1.push_back({a, w});
    else     exp0.push_back({a, w});
  endtask

  task automatic end_stream();
`ifdef IMEM_LOADER_CSUM_EN
    stream.push_back(csum_acc);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!st_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("ready_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_stream();
    @(posedge clk); #1;
    foreach (stream[i]) send_byte(stream[i]);
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!(st_done || st_error) && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 20) chk("end_timeout", cyc, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_status("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_we",    if0.mem_we, 0);
    chk("reset_addr0", if0.mem_addr, 12'h000);
    chk("reset_addr1", if1.mem_addr, 12'hFFF);
    chk("reset_wdata", if0.mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Two-word load at base 000.
    sel = 1'b0;
    begin_load(12'd2);
    add_word(19'h12345, 12'h000);
    add_word(19'h7FFFF, 12'h001);
    end_stream();
    do_start();
    @(negedge clk);
    check_status("t1_run", 0, 0, 0, 1, 1, 1);
    run_stream();
    wait_end(cyc);
    chk("t1_latency", cyc, LAT_WORD);
    check_status("t1_end", 1, 0, ERR_NONE, 0, 0, 0);
    chk("t1_pending", exp0.size(), 0);

    // Empty load.
    begin_load(12'd0);
    end_stream();
    do_start();
    run_stream();
    wait_end(cyc);
    chk("t2_latency", cyc, 0);
    check_status("t2_end", 1, 0, ERR_NONE, 0, 0, 0);

    // Bad count high nibble, then a clean restart.
    stream.delete();
    csum_acc = 8'h00;
    add_byte(8'h00);
    add_byte(8'h10);
    do_start();
    run_stream();
    wait_end(cyc);
    chk("t3_latency", cyc, 0);
    check_status("t3_err", 0, 1, ERR_COUNT, 1, 0, 0);
    begin_load(12'd1);
    add_word(19'h00001, 12'h000);
    end_stream();
    do_start();
    @(negedge clk);
    check_status("t3_restart", 0, 0, ERR_NONE, 1, 1, 1);
    run_stream();
    wait_end(cyc);
    check_status("t3_end", 1, 0, ERR_NONE, 0, 0, 0);

    // Bad pad in the second word: first word written, second not.
    begin_load(12'd2);
    add_word(19'h0ABCD, 12'h000);
    add_byte(8'h11);
    add_byte(8'h22);
    add_byte(8'h08);
    do_start();
    run_stream();
    wait_end(cyc);
    chk("t4_latency", cyc, 0);
    check_status("t4_err", 0, 1, ERR_PAD, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("t4_pending", exp0.size(), 0);

    // Address wrap from base FFF.
    sel = 1'b1;
    begin_load(12'd2);
    add_word(19'h40001, 12'hFFF);
    add_word(19'h00F0F, 12'h000);
    end_stream();
    do_start();
    run_stream();
    wait_end(cyc);
    chk("t5_latency", cyc, LAT_WORD);
    check_status("t5_end", 1, 0, ERR_NONE, 0, 0, 0);
    chk("t5_pending", exp1.size(), 0);
    sel = 1'b0;

`ifdef IMEM_LOADER_CSUM_EN
    // Corrupt checksum: word still written, CPU stays held.
    begin_load(12'd1);
    add_word(19'h00012, 12'h000);
    stream.push_back(csum_acc ^ 8'h01);
    do_start();
    run_stream();
    wait_end(cyc);
    chk("t6_latency", cyc, 0);
    check_status("t6_err", 0, 1, ERR_CSUM, 1, 0, 0);
    chk("t6_pending", exp0.size(), 0);
`endif

    // Gapped stream with reset mid-word, then a clean gapped load.
    gap = 1'b1;
    begin_load(12'd3);
    add_byte(8'h11);
    add_byte(8'h22);
    do_start();
    run_stream();
    rst = 1'b0;
    @(posedge clk); #1;
    check_status("t7_rst", 0, 0, ERR_NONE, 0, 0, 0);
    chk("t7_rst_we",    if0.mem_we, 0);
    chk("t7_rst_addr",  if0.mem_addr, 12'h000);
    chk("t7_rst_wdata", if0.mem_wdata, 0);
    rst = 1'b1;
    begin_load(12'd1);
    add_word(19'h5A5A5, 12'h000);
    end_stream();
    do_start();
    run_stream();
    wait_end(cyc);
    check_status("t7_end", 1, 0, ERR_NONE, 0, 0, 0);
    gap = 1'b0;

    repeat (3) @(negedge clk);
    chk("final_q0", exp0.size(), 0);
    chk("final_q1", exp1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
